// File: rtl/bcd_counter_4dig.sv
// bcd_counter_4dig: four-digit BCD counter for a 7-segment display.
// A prescaler divides enabled clk cycles by PRESCALE. Each prescaler wrap
// applies one count step to the digits. A synchronous load presets the
// digits. The asynchronous clr input clears the whole counter.
// Optional feature macro: BCD_COUNTER_DOWN_COUNT_EN. When it is defined, the
// up_dn input selects the count direction. When it is not defined, the
// counter counts up only and builds no borrow logic.

module bcd_counter_4dig #(
  parameter int unsigned PRESCALE = 500000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        up_dn,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands,
  output logic        tick,
  output logic        ovf
);

  localparam int unsigned DIG_W   = 4;
  localparam int unsigned NUM_DIG = 4;
  localparam int unsigned PCNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  typedef logic [NUM_DIG-1:0][DIG_W-1:0] digits_t;

  // Registered state. Digit index 0 is ones and index 3 is thousands.
  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_d;
  digits_t           digits_q;
  digits_t           digits_d;
  logic              tick_q;
  logic              tick_d;
  logic              ovf_q;
  logic              ovf_d;

  // Combinational helpers.
  digits_t           digits_step_c;
  digits_t           load_digits_c;
  digits_t           load_raw_c;
  logic              wrap_c;
  logic              step_c;

  // Add one to a single digit. The result is {carry_out, new_digit}.
  // Any value of 9 or more rolls over to 0, so the digit stays in BCD range.
  function automatic logic [DIG_W:0] digit_inc(input logic [DIG_W-1:0] d);
    logic [DIG_W:0] r;
    if (d >= DIG_W'(9)) r = {1'b1, DIG_W'(0)};
    else                r = {1'b0, d + DIG_W'(1)};
    return r;
  endfunction

`ifdef BCD_COUNTER_DOWN_COUNT_EN
  // Subtract one from a single digit. The result is {borrow_out, new_digit}.
  // An out-of-range value is treated like 0 and becomes 9.
  function automatic logic [DIG_W:0] digit_dec(input logic [DIG_W-1:0] d);
    logic [DIG_W:0] r;
    if (d == DIG_W'(0) || d > DIG_W'(9)) r = {1'b1, DIG_W'(9)};
    else                                 r = {1'b0, d - DIG_W'(1)};
    return r;
  endfunction
`endif

  // Clamp a preset nibble to BCD. Any value above 9 loads as 0.
  function automatic logic [DIG_W-1:0] bcd_clip(input logic [DIG_W-1:0] n);
    return (n > DIG_W'(9)) ? DIG_W'(0) : n;
  endfunction

`ifndef BCD_COUNTER_DOWN_COUNT_EN
  // up_dn is unused in the up-only build.
  logic unused_up_dn;
  assign unused_up_dn = up_dn;
`endif

  // A step is due on an enabled cycle that closes the prescaler period.
  assign step_c = en && (pcnt_q == PCNT_LAST);

  // Ripple the carry (or borrow) from ones to thousands. A carry out of
  // thousands marks a wrap.
  always_comb begin
    logic           c;
    logic [DIG_W:0] r;
    digits_step_c = digits_q;
    c             = 1'b1;
    r             = '0;
    for (int i = 0; i < int'(NUM_DIG); i++) begin
      r = '0;
      if (c) begin
`ifdef BCD_COUNTER_DOWN_COUNT_EN
        r = up_dn ? digit_inc(digits_q[i]) : digit_dec(digits_q[i]);
`else
        r = digit_inc(digits_q[i]);
`endif
        digits_step_c[i] = r[DIG_W-1:0];
        c                = r[DIG_W];
      end
    end
    wrap_c = c;
  end

  // Clamp each preset nibble on its own.
  always_comb begin
    load_raw_c    = digits_t'(load_val);
    load_digits_c = load_raw_c;
    for (int i = 0; i < int'(NUM_DIG); i++) begin
      load_digits_c[i] = bcd_clip(load_raw_c[i]);
    end
  end

  // Next-state logic. Load wins over a step in the same cycle, and en low
  // holds everything.
  always_comb begin
    pcnt_d   = pcnt_q;
    digits_d = digits_q;
    tick_d   = 1'b0;
    ovf_d    = 1'b0;
    if (load) begin
      digits_d = load_digits_c;
      pcnt_d   = '0;
    end else if (step_c) begin
      pcnt_d   = '0;
      digits_d = digits_step_c;
      tick_d   = 1'b1;
      ovf_d    = wrap_c;
    end else if (en) begin
      pcnt_d   = pcnt_q + PCNT_W'(1);
    end
  end

  // State registers. clr clears them asynchronously.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pcnt_q   <= '0;
      digits_q <= '0;
      tick_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      digits_q <= digits_d;
      tick_q   <= tick_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ones      = digits_q[0];
  assign tens      = digits_q[1];
  assign hundreds  = digits_q[2];
  assign thousands = digits_q[3];
  assign tick      = tick_q;
  assign ovf       = ovf_q;

endmodule
